// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer for a LEGv8-style datapath: fetch handshake, class decode,
// class-specific execute/memory/writeback states, conditional branches, memory watchdog, HALT/FAULT.
module multicycle_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5,
    parameter bit FLAG_EN = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] IR,
    input  logic [3:0]  status,
    input  logic        mem_ready,
    output logic [2:0]  state,
    output logic [2:0]  cls,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        rf_we,
    output logic        flags_we,
    output logic [2:0]  k_sel,
    output logic        halted,
    output logic        fault
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;
    localparam logic [2:0] S_FAULT  = 3'd6;

    localparam logic [2:0] C_DP_REG = 3'd0;
    localparam logic [2:0] C_BRANCH = 3'd1;
    localparam logic [2:0] C_DP_IMM = 3'd2;
    localparam logic [2:0] C_LDST   = 3'd3;
    localparam logic [2:0] C_UNDEF  = 3'd4;

    // Last count value before the watchdog expires: a request waiting TIMEOUT cycles faults.
    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

    logic [2:0]      state_q, state_d;
    logic [2:0]      cls_q, cls_d;
    logic [TO_W-1:0] wd_q, wd_d;
    logic [2:0]      cls_dec;
    logic            is_hlt;
    logic            cond_taken;
    logic            flag_n, flag_z, flag_c, flag_v;
    logic            unused_ir;

    assign unused_ir = ^{IR[24], IR[20:4]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            cls_q   <= C_DP_REG;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        is_hlt = (IR[31:21] == 11'h6A2);
        if (IR[27] && IR[25] && !IR[26])
            cls_dec = C_DP_REG;
        else if (IR[28] && !IR[27] && IR[26])
            cls_dec = C_BRANCH;
        else if (IR[28] && !IR[27] && !IR[26])
            cls_dec = C_DP_IMM;
        else if (IR[27] && !IR[25])
            cls_dec = C_LDST;
        else
            cls_dec = C_UNDEF;
    end

    // ARM condition codes; 14 and 15 are both "always".
    always_comb begin
        flag_n = status[3];
        flag_z = status[2];
        flag_c = status[1];
        flag_v = status[0];
        case (IR[3:0])
            4'd0:    cond_taken = flag_z;
            4'd1:    cond_taken = !flag_z;
            4'd2:    cond_taken = flag_c;
            4'd3:    cond_taken = !flag_c;
            4'd4:    cond_taken = flag_n;
            4'd5:    cond_taken = !flag_n;
            4'd6:    cond_taken = flag_v;
            4'd7:    cond_taken = !flag_v;
            4'd8:    cond_taken = flag_c && !flag_z;
            4'd9:    cond_taken = !(flag_c && !flag_z);
            4'd10:   cond_taken = (flag_n == flag_v);
            4'd11:   cond_taken = (flag_n != flag_v);
            4'd12:   cond_taken = !flag_z && (flag_n == flag_v);
            4'd13:   cond_taken = !(!flag_z && (flag_n == flag_v));
            default: cond_taken = 1'b1;
        endcase
    end

    // The watchdog only advances while a request is stalled; any state change clears it.
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        wd_d    = '0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready)
                    state_d = S_DECODE;
                else if (wd_q == WD_LAST)
                    state_d = S_FAULT;
                else
                    wd_d = wd_q + TO_W'(1);
            end
            S_DECODE: begin
                cls_d = cls_dec;
                if (is_hlt)
                    state_d = S_HALT;
                else if (cls_dec == C_UNDEF)
                    state_d = S_FAULT;
                else
                    state_d = S_EXEC;
            end
            S_EXEC: begin
                case (cls_q)
                    C_DP_REG, C_DP_IMM, C_BRANCH: state_d = S_FETCH;
                    C_LDST:                       state_d = S_MEM;
                    default:                      state_d = S_FAULT;
                endcase
            end
            S_MEM: begin
                if (mem_ready)
                    state_d = IR[22] ? S_WB : S_FETCH;
                else if (wd_q == WD_LAST)
                    state_d = S_FAULT;
                else
                    wd_d = wd_q + TO_W'(1);
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase
    end

    // Strobes are forced low while reset is asserted so an outstanding request drops at once.
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 1'b0;
        rf_we    = 1'b0;
        flags_we = 1'b0;
        k_sel    = 3'b000;
        halted   = (state_q == S_HALT);
        fault    = (state_q == S_FAULT);
        if (reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ready;
                    pc_we   = mem_ready;
                end
                S_EXEC: begin
                    case (cls_q)
                        C_DP_REG: begin
                            rf_we    = 1'b1;
                            flags_we = IR[29] & FLAG_EN;
                        end
                        C_DP_IMM: begin
                            rf_we    = 1'b1;
                            flags_we = IR[29] & FLAG_EN;
                            k_sel    = IR[23] ? 3'b100 : 3'b000;
                        end
                        C_BRANCH: begin
                            if (IR[30]) begin
                                k_sel  = 3'b011;
                                pc_we  = cond_taken;
                                pc_sel = cond_taken;
                            end else begin
                                k_sel  = 3'b010;
                                pc_we  = 1'b1;
                                pc_sel = 1'b1;
                            end
                        end
                        C_LDST:  k_sel = 3'b001;
                        default: k_sel = 3'b000;
                    endcase
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = !IR[22];
                    k_sel   = 3'b001;
                end
                S_WB: begin
                    rf_we = 1'b1;
                    k_sel = 3'b001;
                end
                default: ;
            endcase
        end
    end

    assign state = state_q;
    assign cls   = cls_q;

endmodule
